// File: rtl/vga_timing_pkg.sv
// Shared timing constants, axis timing helper and FSM state type for the VGA timing generator.
package vga_timing_pkg;

    // Default 640x480 @ 60 Hz timing
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    typedef struct packed {
        int unsigned total;
        int unsigned sync_start;
        int unsigned sync_end;    // inclusive
    } axis_timing_t;

    // Derive period and sync window of one axis from its four intervals
    function automatic axis_timing_t axis_timing(
        input int unsigned display,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        axis_timing_t t;
        t.total      = display + front + sync + back;
        t.sync_start = display + front;
        t.sync_end   = display + front + sync - 1;
        return t;
    endfunction

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with registered sync and active flags plus a wrap indicator.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned FRONT   = DEF_H_FRONT,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BACK    = DEF_H_BACK,
    parameter int unsigned W       = 10,
    parameter bit          POL     = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sync,
    output logic         active,
    output logic         wrap
);

    localparam axis_timing_t T = axis_timing(DISPLAY, FRONT, SYNC, BACK);
    localparam logic [W-1:0] LAST = W'(T.total - 1);

    logic [W-1:0] r_cnt;
    logic         r_sync;
    logic         r_active;
    logic [W-1:0] w_cnt_d;
    logic         w_at_last;
    logic         w_load;
    int unsigned  w_cnt_ext;

    // Next position: clear wins over stepping; wrap only on a genuine step off the last count
    always_comb begin
        w_at_last = (r_cnt == LAST);
        w_load    = clr | step;
        wrap      = step & w_at_last & ~clr;
        w_cnt_d   = r_cnt;
        if (clr) begin
            w_cnt_d = '0;
        end else if (step) begin
            w_cnt_d = w_at_last ? '0 : r_cnt + 1'b1;
        end
        w_cnt_ext = 32'(w_cnt_d);
    end

    // Position and its decoded flags are loaded together so they never skew
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sync   <= ~POL;
            r_active <= 1'b0;
        end else if (w_load) begin
            r_cnt    <= w_cnt_d;
            r_sync   <= (w_cnt_ext >= T.sync_start && w_cnt_ext <= T.sync_end) ? POL : ~POL;
            r_active <= (w_cnt_ext < DISPLAY);
        end
    end

    assign cnt    = r_cnt;
    assign sync   = r_sync;
    assign active = r_active;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator: idle/run FSM, H and V axis counters, strobes and frame count.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned HW        = 10,
    parameter int unsigned VW        = 10,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic               sync_clr,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Counters must be able to hold every position of the period
    if ((64'd1 << HW) < 64'(H_TOTAL)) begin : g_hw_check
        $error("vga_timing_gen: HW too narrow for H_TOTAL");
    end
    if ((64'd1 << VW) < 64'(V_TOTAL)) begin : g_vw_check
        $error("vga_timing_gen: VW too narrow for V_TOTAL");
    end

    state_e             r_state;
    state_e             w_state_d;
    logic               w_clr;
    logic               w_h_step;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_h_active;
    logic               w_v_active;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;

    // Next state and counter controls; the first enabled edge and sync_clr both restart at (0,0)
    always_comb begin
        w_state_d = r_state;
        w_clr     = 1'b0;
        w_h_step  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (pix_en) begin
                    w_state_d = StRun;
                    w_clr     = 1'b1;
                end
            end
            StRun: begin
                if (pix_en) begin
                    if (sync_clr) begin
                        w_clr = 1'b1;
                    end else begin
                        w_h_step = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .W       (HW),
        .POL     (HSYNC_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (w_h_step),
        .clr    (w_clr),
        .cnt    (hpos),
        .sync   (hsync),
        .active (w_h_active),
        .wrap   (w_h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .W       (VW),
        .POL     (VSYNC_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (w_h_wrap),
        .clr    (w_clr),
        .cnt    (vpos),
        .sync   (vsync),
        .active (w_v_active),
        .wrap   (w_v_wrap)
    );

    // Strobes last one clk regardless of pix_en; frame count advances only on a natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_line_start  <= w_clr | w_h_wrap;
            r_frame_start <= w_clr | w_v_wrap;
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Both active flags are flops loaded on the same edge as the positions
    assign display_on  = w_h_active & w_v_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default 640x480 instance and a tiny-timing instance driven in lockstep,
// both compared every cycle against a position-level reference model.
module tb_vga_timing_gen;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic pix_en   = 1'b0;
    logic sync_clr = 1'b0;

    always #5 clk = ~clk;

    logic       d_hsync, d_vsync, d_de, d_ls, d_fs;
    logic [9:0] d_h, d_v;
    logic [7:0] d_fc;
    logic       s_hsync, s_vsync, s_de, s_ls, s_fs;
    logic [3:0] s_h;
    logic [2:0] s_v;
    logic [1:0] s_fc;

    vga_timing_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .sync_clr    (sync_clr),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .display_on  (d_de),
        .hpos        (d_h),
        .vpos        (d_v),
        .line_start  (d_ls),
        .frame_start (d_fs),
        .frame_cnt   (d_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
        .HW (4), .VW (3), .FRAME_W (2)
    ) dut_s (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en      (pix_en),
        .sync_clr    (sync_clr),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .display_on  (s_de),
        .hpos        (s_h),
        .vpos        (s_v),
        .line_start  (s_ls),
        .frame_start (s_fs),
        .frame_cnt   (s_fc)
    );

    // Timing of each instance (index 0 = default, 1 = tiny)
    int c_hd[2] = '{640, 8};
    int c_hf[2] = '{16, 2};
    int c_hs[2] = '{96, 2};
    int c_hb[2] = '{48, 2};
    int c_vd[2] = '{480, 4};
    int c_vf[2] = '{10, 1};
    int c_vs[2] = '{2, 1};
    int c_vb[2] = '{33, 1};
    int c_fw[2] = '{8, 2};
    bit c_hp[2] = '{1'b1, 1'b0};
    bit c_vp[2] = '{1'b1, 1'b0};

    // Reference model state
    int m_h[2], m_v[2], m_fc[2];
    bit m_run[2], m_ls[2], m_fs[2];

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; m_h[i] = 0; m_v[i] = 0; m_fc[i] = 0;
            m_ls[i] = 1'b0; m_fs[i] = 1'b0;
        end
    endtask

    // Advance model by one clk edge using the inputs present at that edge
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int ht;
            int vt;
            ht = c_hd[i] + c_hf[i] + c_hs[i] + c_hb[i];
            vt = c_vd[i] + c_vf[i] + c_vs[i] + c_vb[i];
            m_ls[i] = 1'b0;
            m_fs[i] = 1'b0;
            if (!rst_n) begin
                m_run[i] = 1'b0; m_h[i] = 0; m_v[i] = 0; m_fc[i] = 0;
            end else if (pix_en) begin
                if (!m_run[i] || sync_clr) begin
                    m_run[i] = 1'b1; m_h[i] = 0; m_v[i] = 0;
                    m_ls[i] = 1'b1; m_fs[i] = 1'b1;
                end else if (m_h[i] == ht - 1) begin
                    m_h[i] = 0;
                    m_ls[i] = 1'b1;
                    if (m_v[i] == vt - 1) begin
                        m_v[i] = 0;
                        m_fs[i] = 1'b1;
                        m_fc[i] = (m_fc[i] + 1) % (1 << c_fw[i]);
                    end else begin
                        m_v[i] = m_v[i] + 1;
                    end
                end else begin
                    m_h[i] = m_h[i] + 1;
                end
            end
        end
    endtask

    function automatic logic [32:0] exp_vec(input int i);
        logic hs, vs, de;
        logic [9:0] h, v;
        logic [7:0] fc;
        int hss, vss;
        hss = c_hd[i] + c_hf[i];
        vss = c_vd[i] + c_vf[i];
        if (!m_run[i]) begin
            hs = ~c_hp[i]; vs = ~c_vp[i]; de = 1'b0;
        end else begin
            hs = (m_h[i] >= hss && m_h[i] < hss + c_hs[i]) ? c_hp[i] : ~c_hp[i];
            vs = (m_v[i] >= vss && m_v[i] < vss + c_vs[i]) ? c_vp[i] : ~c_vp[i];
            de = (m_h[i] < c_hd[i]) && (m_v[i] < c_vd[i]);
        end
        h  = 10'(m_h[i]);
        v  = 10'(m_v[i]);
        fc = 8'(m_fc[i]);
        return {hs, vs, de, h, v, m_ls[i], m_fs[i], fc};
    endfunction

    function automatic logic [32:0] act_vec(input int i);
        if (i == 0) return {d_hsync, d_vsync, d_de, d_h, d_v, d_ls, d_fs, d_fc};
        return {s_hsync, s_vsync, s_de, 6'b0, s_h, 7'b0, s_v, s_ls, s_fs, 6'b0, s_fc};
    endfunction

    // One clk edge with the given inputs; returns 1 ns after the edge
    task automatic tick(input bit pe, input bit sc);
        pix_en   = pe;
        sync_clr = sc;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL reset inst%0d: got %h want %h", i, act_vec(i), exp_vec(i));
            end
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL idle_hold inst%0d cyc%0d: got %h want %h",
                             i, k, act_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_first_edge();
        tick(1'b1, 1'b0);
        checks++;
        if ({d_h, d_v, d_de, d_ls, d_fs, d_hsync} !== {10'd0, 10'd0, 4'b1110}) begin
            errors++;
            $display("FAIL first_edge: got h=%0d v=%0d de=%b ls=%b fs=%b hs=%b want 0 0 1 1 1 0",
                     d_h, d_v, d_de, d_ls, d_fs, d_hsync);
        end
        tick(1'b1, 1'b0);
        checks++;
        if ({d_h, d_ls, d_fs} !== {10'd1, 2'b00}) begin
            errors++;
            $display("FAIL strobe_clear: got h=%0d ls=%b fs=%b want 1 0 0", d_h, d_ls, d_fs);
        end
    endtask

    task automatic test_line();
        int hs_cnt;
        int last_ls;
        int last_fs;
        hs_cnt  = 0;
        last_ls = -1;
        last_fs = -1;
        for (int k = 0; k < 1700; k++) begin
            tick(1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL line_run inst%0d cyc%0d: got %h want %h",
                             i, k, act_vec(i), exp_vec(i));
                end
            end
            if (d_v == 10'd0 && d_hsync) hs_cnt++;
            if (d_ls) begin
                if (last_ls >= 0) begin
                    checks++;
                    if (k - last_ls != 800) begin
                        errors++;
                        $display("FAIL line_period: got %0d want 800", k - last_ls);
                    end
                end
                last_ls = k;
            end
            if (s_fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (k - last_fs != 98) begin
                        errors++;
                        $display("FAIL small_frame_period: got %0d want 98", k - last_fs);
                    end
                end
                last_fs = k;
            end
        end
        checks++;
        if (hs_cnt != 96) begin
            errors++;
            $display("FAIL hsync_width: got %0d want 96", hs_cnt);
        end
    endtask

    task automatic test_duty();
        int last_ls;
        bit prev_ls;
        last_ls = -1;
        prev_ls = 1'b0;
        for (int k = 0; k < 6600; k++) begin
            tick(k % 4 == 0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL duty_run inst%0d cyc%0d: got %h want %h",
                             i, k, act_vec(i), exp_vec(i));
                end
            end
            if (d_ls) begin
                checks++;
                if (prev_ls) begin
                    errors++;
                    $display("FAIL strobe_width: got 2+ clks want 1");
                end
                if (last_ls >= 0) begin
                    checks++;
                    if (k - last_ls != 3200) begin
                        errors++;
                        $display("FAIL duty_line_period: got %0d want 3200", k - last_ls);
                    end
                end
                last_ls = k;
            end
            prev_ls = d_ls;
        end
    endtask

    task automatic test_sync_clr();
        int n;
        logic [7:0] fc0;
        logic [1:0] fc1;
        n = 0;
        while (m_h[0] != 300 && n < 900) begin
            tick(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (n >= 900) begin
            errors++;
            $display("FAIL clr_wait: got timeout want hpos 300");
        end
        fc0 = d_fc;
        tick(1'b1, 1'b1);
        checks++;
        if ({d_h, d_v, d_fs, d_ls, d_fc} !== {10'd0, 10'd0, 2'b11, fc0}) begin
            errors++;
            $display("FAIL sync_clr: got h=%0d v=%0d fs=%b ls=%b fc=%0d want 0 0 1 1 %0d",
                     d_h, d_v, d_fs, d_ls, d_fc, fc0);
        end
        n = 0;
        while (!(m_h[1] == 13 && m_v[1] == 6) && n < 200) begin
            tick(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL clr_wrap_wait: got timeout want (13,6)");
        end
        fc1 = s_fc;
        tick(1'b1, 1'b1);
        checks++;
        if ({s_h, s_v, s_fs, s_fc} !== {4'd0, 3'd0, 1'b1, fc1}) begin
            errors++;
            $display("FAIL clr_at_wrap: got h=%0d v=%0d fs=%b fc=%0d want 0 0 1 %0d",
                     s_h, s_v, s_fs, s_fc, fc1);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL clr_model inst%0d: got %h want %h", i, act_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (m_h[0] != 200 && n < 900) begin
            tick(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (n >= 900 || d_h !== 10'd200) begin
            errors++;
            $display("FAIL arst_wait: got hpos %0d want 200", d_h);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL async_reset inst%0d: got %h want %h", i, act_vec(i), exp_vec(i));
            end
        end
        tick(1'b1, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL post_reset_idle inst%0d: got %h want %h",
                             i, act_vec(i), exp_vec(i));
                end
            end
        end
        tick(1'b1, 1'b0);
        checks++;
        if ({d_h, d_v, d_de, d_ls, d_fs, s_h, s_v, s_fs} !== {20'd0, 3'b111, 7'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart: got h=%0d v=%0d de=%b ls=%b fs=%b want 0 0 1 1 1",
                     d_h, d_v, d_de, d_ls, d_fs);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d: got %h want %h",
                             i, k, act_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_edge();
        test_line();
        test_duty();
        test_sync_clr();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the existing 640x480 sync generator. It produces VGA horizontal and vertical timing from one clock, advancing only on a pixel-clock enable. Timing, sync polarity and counter widths are all configurable, and every output is registered and skew-free. It sits between the top-level clock/reset and the pixel-colour logic, which consumes `hpos`, `vpos`, `display_on` and the line/frame strobes.

## Interface

Parameters:
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BACK`, 48: horizontal back porch
- `V_DISPLAY`, 480: visible lines
- `V_FRONT`, 10: vertical front porch (bottom border)
- `V_SYNC`, 2: vsync width in lines
- `V_BACK`, 33: vertical back porch (top border)
- `HSYNC_POL`, 1: hsync level during the sync interval
- `VSYNC_POL`, 1: vsync level during the sync interval
- `HW`, 10: `hpos` width; elaboration error if 2^HW < H_TOTAL
- `VW`, 10: `vpos` width; elaboration error if 2^VW < V_TOTAL
- `FRAME_W`, 8: `frame_cnt` width

Ports:
- `clk`, in, 1: clock
- `rst_n`, in, 1: reset, asynchronous, active-low
- `pix_en`, in, 1: pixel-clock enable; timing advances only on clk edges where it is high
- `sync_clr`, in, 1: restart frame at (0,0); sampled only when `pix_en`=1
- `hsync`, out, 1: horizontal sync at `HSYNC_POL` level
- `vsync`, out, 1: vertical sync at `VSYNC_POL` level
- `display_on`, out, 1: current position is visible
- `hpos`, out, HW: horizontal position
- `vpos`, out, VW: vertical position
- `line_start`, out, 1: one-clk pulse when `hpos` becomes 0
- `frame_start`, out, 1: one-clk pulse when (`hpos`,`vpos`) becomes (0,0)
- `frame_cnt`, out, FRAME_W: completed-frame count

## Operation

- Derived values: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- The hsync interval is `hpos` in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. The vsync interval is defined the same way on `vpos`.
- `display_on` = (`hpos` < H_DISPLAY) && (`vpos` < V_DISPLAY).
- Two-state FSM:
  - IDLE, entered on reset: all outputs hold their reset values.
  - RUN: entered on the first clk edge with `pix_en`=1. That edge loads position (0,0) with `display_on`=1 and `line_start`=`frame_start`=1.
- RUN, on each `pix_en` edge:
  - `hpos` increments.
  - At H_TOTAL-1, `hpos` wraps to 0 and `vpos` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0 and `frame_cnt` increments modulo 2^FRAME_W.
- `sync_clr`=1 on a `pix_en` edge in RUN forces the next position to (0,0) and pulses both strobes. `frame_cnt` is unchanged, and `sync_clr` takes priority over a simultaneous natural wrap. `sync_clr` in IDLE is ignored.
- With `pix_en`=0, all outputs hold. The exceptions are the strobes, which always clear on the following clk edge.
- Reset values: `hpos`=0, `vpos`=0, `display_on`=0, `line_start`=0, `frame_start`=0, `frame_cnt`=0, `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL.

## Timing

- All outputs are flops updated on the same edge from next-state position. Sync, `display_on`, strobes and position have zero relative skew.
- Latency is zero: the outputs describe the position currently shown in `hpos`/`vpos`.
- Strobe width is exactly 1 clk, independent of the `pix_en` duty cycle.
- `rst_n` low forces reset values immediately, without a clock edge, including mid-line. On release the block stays in IDLE until the first `pix_en` edge.
- Line period is H_TOTAL `pix_en` edges; frame period is H_TOTAL×V_TOTAL `pix_en` edges.

## Structure

- Package `vga_timing_pkg`:
  - default 640x480 timing constants
  - a function computing total/sync-start/sync-end from the four interval parameters
  - the FSM state typedef
- Sub-module `vga_axis_counter`, instantiated once for H and once for V. Parameters: the four intervals, width and polarity. Inputs: `step`, `clr`. Outputs: `cnt`, `sync`, `active`, `wrap`.
- Top-level contents: the FSM, strobes, `frame_cnt` and the elaboration width checks.

## Test plan

- Reset, then `pix_en`=1 constant → first edge gives `hpos`=0, `vpos`=0, `display_on`=1, both strobes=1. `hsync` is high for `hpos` 656..751 (96 clks); `line_start` recurs every 800 clks.
- Full frame run → `vsync` high for `vpos` 490..491 (1600 clks); `frame_cnt` goes 0→1 exactly 420000 clks after the first frame_start; `display_on` is low for `vpos` ≥ 480.
- `pix_en` high 1 clk in 4 → line period 3200 clks, `line_start` width 1 clk, outputs stable between enables.
- `sync_clr` at (300,100) → next enabled edge gives (0,0) with `frame_start`=1 and `frame_cnt` unchanged. `sync_clr` coincident with (799,524) → `frame_cnt` unchanged.
- `rst_n` low at (200,50), asynchronous to clk → outputs at reset values before the next edge. After release with `pix_en`=0 for 10 clks, the block stays IDLE; first enable → (0,0).
- Parameters H=8/2/2/2, V=4/1/1/1, HSYNC_POL=0, VSYNC_POL=0 → `hsync` low for `hpos` 10..11, `vsync` low at `vpos` 5, frame = 14×7 = 98 enables.
